// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, functs, FSM state encoding and ALUcontrol codes shared by the multi-cycle core.
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SLL = 4'd3, ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5, ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_NOR = 4'd8, ALU_XOR = 4'd9;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, BRANCH, JUMP, EXEC_I, IWB, JAL, JR
  } state_t;
  typedef enum logic [2:0] {CL_NONE, CL_ADDR, CL_R, CL_I, CL_BR} cls_t;
  // FETCH doubles as the "unsupported opcode" target
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_RTYPE: return funct == F_JR ? JR : EXEC_R;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_J: return JUMP;
      OP_JAL: return JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return EXEC_I;
      default: return FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps state class and Op/Funct to ALUcontrol, ExtOp and an unsupported-funct flag.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int ALUC_W = 4
) (
  input  cls_t              cls,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] aluc,
  output logic              extop,
  output logic              funct_illegal
);
  logic [3:0] code;
  always_comb begin
    code = ALU_ADD;
    extop = 1'b0;
    funct_illegal = 1'b0;
    case (cls)
      CL_ADDR: extop = 1'b1;
      CL_BR: code = ALU_SUB;
      CL_R:
        case (funct)
          F_ADD, F_ADDU: code = ALU_ADD;
          F_SUB, F_SUBU: code = ALU_SUB;
          F_AND: code = ALU_AND;
          F_OR: code = ALU_OR;
          F_XOR: code = ALU_XOR;
          F_NOR: code = ALU_NOR;
          F_SLT: code = ALU_SLT;
          F_SLL: code = ALU_SLL;
          F_SRL: code = ALU_SRL;
          default: funct_illegal = 1'b1;
        endcase
      CL_I:
        case (op)
          OP_SLTI: begin code = ALU_SLT; extop = 1'b1; end
          OP_ANDI: code = ALU_AND;
          OP_ORI: code = ALU_OR;
          OP_XORI: code = ALU_XOR;
          OP_LUI: code = ALU_LUI;
          default: extop = 1'b1;
        endcase
      default: ;
    endcase
  end
  assign aluc = ALUC_W'(code);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control sequencer for the multi-cycle MIPS datapath.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUC_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWriteEn,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [1:0]         PCSource,
  output logic [ALUC_W-1:0]  ALUcontrol,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);
  state_t st;
  cls_t cls;
  logic [ALUC_W-1:0] aluc;
  logic ext, fill;
  assign cls = (st == DECODE || st == MEMADR) ? CL_ADDR : st == EXEC_R ? CL_R :
               st == EXEC_I ? CL_I : st == BRANCH ? CL_BR : CL_NONE;
  mc_alu_decoder #(.ALUC_W(ALUC_W)) u_dec (
    .cls(cls), .op(Op), .funct(Funct), .aluc(aluc), .extop(ext), .funct_illegal(fill)
  );
  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else
      case (st)
        FETCH: st <= DECODE;
        DECODE: st <= decode_next(Op, Funct);
        MEMADR: st <= Op == OP_SW ? MEMWR : MEMRD;
        MEMRD: st <= MEMWB;
        EXEC_R: st <= fill ? FETCH : RWB;
        EXEC_I: st <= IWB;
        default: st <= FETCH;
      endcase
  end
  always_comb begin
    PCWriteEn = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegDst = 2'b00;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    case (st)
      FETCH: begin MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'b01; PCWriteEn = 1'b1; end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD: begin MemRead = 1'b1; IorD = 1'b1; end
      MEMWB: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      MEMWR: begin MemWrite = 1'b1; IorD = 1'b1; end
      EXEC_R: ALUSrcA = 1'b1;
      RWB: begin RegWrite = 1'b1; RegDst = 2'b01; end
      EXEC_I: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      IWB: RegWrite = 1'b1;
      BRANCH: begin ALUSrcA = 1'b1; PCSource = 2'b01; PCWriteEn = Zero ^ (Op == OP_BNE); end
      JUMP: begin PCSource = 2'b10; PCWriteEn = 1'b1; end
      JAL: begin PCSource = 2'b10; PCWriteEn = 1'b1; RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10; end
      JR: begin PCSource = 2'b11; PCWriteEn = 1'b1; end
      default: ;
    endcase
    // reset suppresses every write so an aborted instruction leaves no trace
    if (rst) begin
      {PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite} = '0;
      {ALUSrcA, ALUSrcB, PCSource} = '0;
    end
  end
  assign ExtOp = rst ? 1'b0 : ext;
  assign ALUcontrol = rst ? ALUC_W'(ALU_ADD) : aluc;
  assign Illegal = !rst && ((st == DECODE && decode_next(Op, Funct) == FETCH) || (st == EXEC_R && fill));
  assign State = STATE_W'(st);
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench; stimulus queues per-cycle expected outputs, a monitor compares them.
module tb_mc_control_fsm;
  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtOp, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALUcontrol, State;
  int applied = 0, miscompares = 0;
  typedef struct {string name; logic [24:0] v;} exp_t;
  exp_t q[$];
  bit done = 1'b0;

  mc_control_fsm #(.STATE_W(4), .ALUC_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .PCWriteEn(PCWriteEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .PCSource(PCSource),
    .ALUcontrol(ALUcontrol), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] v(input logic pcw, iord, mr, mw, irw, input logic [1:0] rd, mtr,
                                    input logic rw, sa, input logic [1:0] sb, input logic ext,
                                    input logic [1:0] ps, input logic [3:0] alu, input logic ill,
                                    input logic [3:0] st);
    return {pcw, iord, mr, mw, irw, rd, mtr, rw, sa, sb, ext, ps, alu, ill, st};
  endfunction
  function automatic logic [24:0] f_fetch(); return v(1,0,1,0,1,0,0,0,0,1,0,0,2,0,0); endfunction
  function automatic logic [24:0] f_dec(input logic ill); return v(0,0,0,0,0,0,0,0,0,3,1,0,2,ill,1); endfunction
  function automatic logic [24:0] f_ma(); return v(0,0,0,0,0,0,0,0,1,2,1,0,2,0,2); endfunction
  function automatic logic [24:0] f_mr(); return v(0,1,1,0,0,0,0,0,0,0,0,0,2,0,3); endfunction
  function automatic logic [24:0] f_mwb(); return v(0,0,0,0,0,0,1,1,0,0,0,0,2,0,4); endfunction
  function automatic logic [24:0] f_mw(); return v(0,1,0,1,0,0,0,0,0,0,0,0,2,0,5); endfunction
  function automatic logic [24:0] f_er(input logic [3:0] alu, input logic ill); return v(0,0,0,0,0,0,0,0,1,0,0,0,alu,ill,6); endfunction
  function automatic logic [24:0] f_rwb(); return v(0,0,0,0,0,1,0,1,0,0,0,0,2,0,7); endfunction
  function automatic logic [24:0] f_br(input logic pcw); return v(pcw,0,0,0,0,0,0,0,1,0,0,1,6,0,8); endfunction
  function automatic logic [24:0] f_j(); return v(1,0,0,0,0,0,0,0,0,0,0,2,2,0,9); endfunction
  function automatic logic [24:0] f_ei(input logic ext, input logic [3:0] alu); return v(0,0,0,0,0,0,0,0,1,2,ext,0,alu,0,10); endfunction
  function automatic logic [24:0] f_iwb(); return v(0,0,0,0,0,0,0,1,0,0,0,0,2,0,11); endfunction
  function automatic logic [24:0] f_jal(); return v(1,0,0,0,0,2,2,1,0,0,0,2,2,0,12); endfunction
  function automatic logic [24:0] f_jr(); return v(1,0,0,0,0,0,0,0,0,0,0,3,2,0,13); endfunction
  function automatic logic [24:0] f_rst(input logic [3:0] st); return v(0,0,0,0,0,0,0,0,0,0,0,0,2,0,st); endfunction

  task automatic push(input string name, input logic [24:0] e);
    q.push_back('{name, e});
  endtask
  task automatic set(input logic [5:0] op, input logic [5:0] f, input logic z);
    Op = op; Funct = f; Zero = z;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rtype(input string nm, input logic [5:0] f, input logic [3:0] alu);
    set(6'h00, f, 0); push(nm, f_fetch()); push(nm, f_dec(0)); push(nm, f_er(alu, 0)); push(nm, f_rwb()); run(4);
  endtask
  task automatic itype(input string nm, input logic [5:0] op, input logic ext, input logic [3:0] alu);
    set(op, 0, 0); push(nm, f_fetch()); push(nm, f_dec(0)); push(nm, f_ei(ext, alu)); push(nm, f_iwb()); run(4);
  endtask
  task automatic branch(input string nm, input logic [5:0] op, input logic z, input logic pcw);
    set(op, 0, z); push(nm, f_fetch()); push(nm, f_dec(0)); push(nm, f_br(pcw)); run(3);
  endtask

  always @(negedge clk) begin
    logic [24:0] act;
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
             ExtOp, PCSource, ALUcontrol, Illegal, State};
      applied++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", e.name, act, e.v, State, e.v[3:0]);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    push("reset", f_rst(0));
    run(1);
    rst = 1'b0;
    set(6'h23, 0, 0);
    push("lw", f_fetch()); push("lw", f_dec(0)); push("lw", f_ma()); push("lw", f_mr()); push("lw", f_mwb()); run(5);
    set(6'h2B, 0, 0);
    push("sw", f_fetch()); push("sw", f_dec(0)); push("sw", f_ma()); push("sw", f_mw()); run(4);
    rtype("slt", 6'h2A, 7);
    rtype("add", 6'h20, 2);
    rtype("subu", 6'h23, 6);
    rtype("nor", 6'h27, 8);
    rtype("sll", 6'h00, 3);
    rtype("srl", 6'h02, 4);
    set(6'h00, 6'h3F, 0);
    push("badfunct", f_fetch()); push("badfunct", f_dec(0)); push("badfunct", f_er(2, 1)); run(3);
    set(6'h00, 6'h08, 0);
    push("jr", f_fetch()); push("jr", f_dec(0)); push("jr", f_jr()); run(3);
    branch("beq_z1", 6'h04, 1, 1);
    branch("beq_z0", 6'h04, 0, 0);
    branch("bne_z1", 6'h05, 1, 0);
    branch("bne_z0", 6'h05, 0, 1);
    itype("lui", 6'h0F, 0, 5);
    itype("ori", 6'h0D, 0, 1);
    itype("andi", 6'h0C, 0, 0);
    itype("xori", 6'h0E, 0, 9);
    itype("addi", 6'h08, 1, 2);
    itype("slti", 6'h0A, 1, 7);
    set(6'h02, 0, 0);
    push("j", f_fetch()); push("j", f_dec(0)); push("j", f_j()); run(3);
    set(6'h03, 0, 0);
    push("jal", f_fetch()); push("jal", f_dec(0)); push("jal", f_jal()); run(3);
    set(6'h3F, 0, 0);
    push("badop", f_fetch()); push("badop", f_dec(1)); run(2);
    set(6'h2B, 0, 0);
    push("sw_rst", f_fetch()); push("sw_rst", f_dec(0)); push("sw_rst", f_ma()); push("sw_rst", f_rst(5)); run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    set(6'h02, 0, 0);
    push("after_rst", f_fetch()); push("after_rst", f_dec(0)); push("after_rst", f_j()); run(3);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares += q.size();
      $display("FAIL scoreboard: %0d expected entries never compared, required 0", q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, applied %0d", applied);
      $fatal(1);
    end
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control sequencer for the multi-cycle MIPS core.
- Decodes Op/Funct from the instruction register and steps a Moore FSM through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select and write enable, plus the 4-bit ALUcontrol code for the shared ALU.
- Folds the ALU Zero flag into the PC write enable for beq/bne.

Parameters:
- STATE_W, 4, width of state register and debug state output.
- ALUC_W, 4, ALUcontrol width; must match the ALU.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- Op  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- Zero  input  1  ALU zero flag (A-B==0)
- PCWriteEn  output  1  PC register load (combined unconditional/branch)
- IorD  output  1  memory address select: 0 PC, 1 ALUOut
- MemRead  output  1  memory read
- MemWrite  output  1  memory write
- IRWrite  output  1  instruction register load
- RegDst  output  2  write register select: 00 rt, 01 rd, 10 $31
- MemtoReg  output  2  write data select: 00 ALUOut, 01 MDR, 10 PC
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 PC, 1 A
- ALUSrcB  output  2  00 B, 01 const 4, 10 ext(imm), 11 sext(imm)<<2
- ExtOp  output  1  1 sign-extend imm, 0 zero-extend
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- ALUcontrol  output  4  AND0 OR1 ADD2 SLL3 SRL4 LUI5 SUB6 SLT7 NOR8 XOR9
- Illegal  output  1  one-cycle pulse on unsupported Op/Funct
- State  output  STATE_W  current state (debug)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst high at a rising edge puts the FSM in FETCH next cycle.
- Reset outputs: while rst is high, all write enables (PCWriteEn, MemRead, MemWrite, IRWrite, RegWrite) and Illegal are 0; selects are 0; ALUcontrol is ADD.
- Reset mid-instruction: aborts the instruction; no partial write occurs in the reset cycle.
- States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC_R6 RWB7 BRANCH8 JUMP9 EXEC_I10 IWB11 JAL12 JR13.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWriteEn=1. Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ADD (branch target into ALUOut). Next state by Op:
  - lw 0x23 / sw 0x2B -> MEMADR
  - 0x00 -> JR if Funct=0x08, else EXEC_R
  - beq 0x04 / bne 0x05 -> BRANCH
  - j 0x02 -> JUMP
  - jal 0x03 -> JAL
  - addi 08, slti 0A, andi 0C, ori 0D, xori 0E, lui 0F -> EXEC_I
  - other -> FETCH with Illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next: FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUcontrol from Funct:
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 00 SLL, 02 SRL
  - other Funct -> ADD, Illegal=1, next FETCH, no RWB
- RWB: RegWrite=1, RegDst=01, MemtoReg=00. Next: FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ExtOp=1 for addi/slti, 0 for andi/ori/xori/lui. ALUcontrol: addi ADD, slti SLT, andi AND, ori OR, xori XOR, lui LUI. Next: IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01.
  - PCWriteEn = Zero for beq, ~Zero for bne.
  - Zero is sampled combinationally in this cycle only. Next: FETCH.
- JUMP: PCSource=10, PCWriteEn=1. Next: FETCH.
- JAL: PCSource=10, PCWriteEn=1, RegWrite=1, RegDst=10, MemtoReg=10. PC already holds PC+4 from FETCH. Next: FETCH.
- JR: PCSource=11, PCWriteEn=1. Next: FETCH.
- Output timing: Moore outputs decoded from State. ALUcontrol, ExtOp and PCWriteEn may also depend on Op/Funct/Zero, which stay stable because IRWrite is asserted only in FETCH.
- Latencies in cycles: lw 5; sw 4; R-type 4; I-type 4; beq/bne 3; j, jal, jr 3.

Decomposition:
- Package mc_pkg holds: opcode and funct localparams, state encoding, and the ALUcontrol codes. The ALU must import the same ALUcontrol codes.
- One sub-module, mc_alu_decoder: a combinational map from (state class, Op, Funct) to {ALUcontrol, ExtOp, funct_illegal}.

Test Plan:
- rst high 2 cycles, then low -> State=0; in cycle 1 after release, IRWrite=1, PCWriteEn=1, ALUSrcB=01, ALUcontrol=2.
- Op=0x23 (lw) -> States 0,1,2,3,4,0; MemRead high in states 0 and 3; RegWrite=1, MemtoReg=01 only in state 4.
- Op=0x00, Funct=0x2A -> ALUcontrol=7 in EXEC_R; RegWrite=1, RegDst=01 in RWB. Repeat with Funct=0x3F -> Illegal pulse, RWB skipped.
- Op=0x04 with Zero=1 -> PCWriteEn=1, PCSource=01 in BRANCH. With Zero=0 -> PCWriteEn=0. Repeat with Op=0x05 -> results inverted.
- Op=0x0F (lui) -> ExtOp=0, ALUSrcB=10, ALUcontrol=5 in EXEC_I. Op=0x03 (jal) -> RegDst=10, MemtoReg=10, PCSource=10 in the same cycle.
- Assert rst during MEMWR of sw -> MemWrite=0 that cycle; State=0 next cycle.
